mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Memory-stage load/store unit. It sits directly downstream of the pipeline controller and consumes the M-stage memory enable and write signals. It checks alignment and raises address-error exceptions, drives the data-side SRAM-like request/handshake bus, stalls the pipeline until the access completes, and returns the sign- or zero-extended load data. A result that arrives while the pipeline is stalled for another reason is held until the M stage advances.

## Interface
Parameters: none.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  reset, asynchronous, active-low
- memenM  in  1  M-stage instruction is a load/store
- memwriteM  in  1  1 = store, 0 = load (valid with memenM)
- lsopM  in  3  000 LB, 001 LBU, 010 LH, 011 LHU, 100 LW, 101 SB, 110 SH, 111 SW
- addrM  in  32  effective address (ALU result)
- writedataM  in  32  store data, right-aligned
- stallM  in  1  global M-stage stall from the hazard unit
- flushM  in  1  M-stage flush (exception/eret)
- data_req  out  1  request valid
- data_wr  out  1  1 = write
- data_size  out  2  0 byte, 1 half, 2 word
- data_addr  out  32  request address (= addrM)
- data_wdata  out  32  lane-replicated store data
- data_addr_ok  in  1  request accepted this cycle
- data_data_ok  in  1  read data / write ack this cycle
- data_rdata  in  32  aligned word containing the addressed bytes
- stall_reqM  out  1  to hazard unit: hold M and earlier stages
- adelM  out  1  load address error
- adesM  out  1  store address error
- badvaddrM  out  32  faulting address (= addrM)
- readdataM  out  32  extended load result

## Operation
- Misaligned access: a halfword access (LH/LHU/SH) with addr[0]=1, or a word access (LW/SW) with addr[1:0]!=0. This check is combinational and gated by memenM.
  - adelM = memenM & ~memwriteM & misaligned.
  - adesM = memenM & memwriteM & misaligned.
- access_valid = memenM & ~adelM & ~adesM & ~flushM.
- data_size comes from lsopM. data_wr = memwriteM.
- data_wdata:
  - SB: {4{wd[7:0]}}
  - SH: {2{wd[15:0]}}
  - SW: wd
- State machine has four states: IDLE, ADDR, DATA, DONE.
  - IDLE: data_req = access_valid. If access_valid & data_addr_ok, go to DATA. If access_valid & ~data_addr_ok, go to ADDR.
  - ADDR: data_req = 1, with address, size and data held stable (M is stalled). On data_addr_ok, go to DATA.
  - DATA: data_req = 0. On data_data_ok:
    - If stallM, go to DONE and latch the extended data.
    - Otherwise go to IDLE.
  - DONE: data_req = 0. If ~stallM or flushM, go to IDLE. A DONE access is never reissued.
- stall_reqM = (IDLE & access_valid) | ADDR | (DATA & ~data_data_ok).
- Load extension: the lane is selected by addrM[1:0] within data_rdata.
  - LB / LBU: byte, sign- or zero-extended to 32 bits.
  - LH / LHU: halfword (addr[1] selects the lane), sign- or zero-extended.
  - LW: the whole word.
- readdataM = extended data_rdata in DATA when data_data_ok; the held register in DONE; 0 otherwise. Stores produce readdataM = 0.
- Flush while in ADDR or DATA: a request already asserted is never withdrawn. The transaction runs to data_data_ok, a cancel flag discards its result, and stall_reqM remains asserted until completion. The FSM then returns to IDLE, not DONE.
- Reset: state IDLE, held data 0, cancel flag 0. All outputs are then purely combinational from the inputs; with memenM = 0 every output is 0 except data_addr, data_wdata and badvaddrM.

## Timing
- For a zero-wait slave (addr_ok with the request, data_ok one cycle later), a load or store stalls M for exactly 1 cycle and completes in the second cycle.
- Each cycle of addr_ok delay adds one stall cycle; each cycle of data_ok delay adds one stall cycle.
- At most one transaction is outstanding. A new request cannot be issued until the FSM is in IDLE.
- A misaligned access raises adelM/adesM in the same cycle, issues no request and produces no stall.
- data_data_ok together with stallM = 1 goes to DONE. The held data is presented until the first cycle with stallM = 0, and M advances on that edge.

## Test plan
- LW at 0x0000_1004, zero-wait slave returning 0xDEADBEEF: req for 1 cycle, stall_reqM = 1 for 1 cycle, then readdataM = 0xDEADBEEF with stall_reqM = 0.
- LB at 0x0000_1003 with rdata 0x80FF_0011 gives readdataM = 0xFFFF_FF80. LBU at the same address gives 0x0000_0080. LHU at 0x0000_1002 gives 0x0000_80FF.
- SH at 0x0000_2001: adesM = 1, badvaddrM = 0x0000_2001, data_req = 0, stall_reqM = 0. LW at 0x0000_2002: adelM = 1.
- SB with writedataM = 0x1234_56AB, addr_ok delayed 3 cycles: data_wdata = 0xABAB_ABAB held stable, data_size = 0, stall_reqM high until data_ok.
- LW returning 0x0000_0042 with stallM held 2 more cycles after data_ok: FSM stays in DONE, readdataM holds 0x42, no second data_req, and the FSM goes to IDLE when stallM falls.
- flushM in ADDR: data_req stays high until addr_ok, the result is discarded, and the FSM ends in IDLE. Asserting rst (low) mid-DATA forces IDLE with data_req = 0 immediately.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: alignment check, data-side SRAM-like handshake,
// pipeline stall generation and load-data extension with a hold register for late stalls.
module mem_access_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        memenM,
    input  logic        memwriteM,
    input  logic [2:0]  lsopM,
    input  logic [31:0] addrM,
    input  logic [31:0] writedataM,
    input  logic        stallM,
    input  logic        flushM,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic        stall_reqM,
    output logic        adelM,
    output logic        adesM,
    output logic [31:0] badvaddrM,
    output logic [31:0] readdataM
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] held_data;
    logic        cancel;

    logic        is_half;
    logic        is_word;
    logic        misaligned;
    logic        access_valid;
    logic [1:0]  size_code;
    logic        discard;
    logic [31:0] byte_lane;
    logic [31:0] half_lane;
    logic [31:0] load_ext;

    assign is_half    = (lsopM == 3'b010) | (lsopM == 3'b011) | (lsopM == 3'b110);
    assign is_word    = (lsopM == 3'b100) | (lsopM == 3'b111);
    assign misaligned = (is_half & addrM[0]) | (is_word & (addrM[1:0] != 2'b00));

    assign adelM = memenM & ~memwriteM & misaligned;
    assign adesM = memenM &  memwriteM & misaligned;

    // Reset also blocks new requests so an access caught by reset is never re-launched.
    assign access_valid = rst & memenM & ~adelM & ~adesM & ~flushM;

    assign size_code = is_word ? 2'd2 : (is_half ? 2'd1 : 2'd0);
    assign data_size = memenM ? size_code : 2'd0;
    assign data_wr   = memenM & memwriteM;
    assign data_addr = addrM;
    assign badvaddrM = addrM;

    always_comb begin
        data_wdata = writedataM;
        case (size_code)
            2'd0:    data_wdata = {4{writedataM[7:0]}};
            2'd1:    data_wdata = {2{writedataM[15:0]}};
            default: data_wdata = writedataM;
        endcase
    end

    assign byte_lane = data_rdata >> {addrM[1:0], 3'b000};
    assign half_lane = addrM[1] ? {16'h0000, data_rdata[31:16]} : {16'h0000, data_rdata[15:0]};

    always_comb begin
        load_ext = 32'h0;
        if (!memwriteM) begin
            case (lsopM)
                3'b000:  load_ext = {{24{byte_lane[7]}}, byte_lane[7:0]};
                3'b001:  load_ext = {24'h0, byte_lane[7:0]};
                3'b010:  load_ext = {{16{half_lane[15]}}, half_lane[15:0]};
                3'b011:  load_ext = {16'h0, half_lane[15:0]};
                3'b100:  load_ext = data_rdata;
                default: load_ext = 32'h0;
            endcase
        end
    end

    // A flush arriving in the completion cycle discards the result just like an earlier one.
    assign discard = cancel | flushM;

    assign data_req   = ((state == IDLE) & access_valid) | (state == ADDR);
    assign stall_reqM = ((state == IDLE) & access_valid) | (state == ADDR)
                      | ((state == DATA) & ~data_data_ok);

    always_comb begin
        readdataM = 32'h0;
        if ((state == DATA) && data_data_ok && !discard)
            readdataM = load_ext;
        else if (state == DONE)
            readdataM = held_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            held_data <= 32'h0;
            cancel    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cancel <= 1'b0;
                    if (access_valid)
                        state <= data_addr_ok ? DATA : ADDR;
                end
                ADDR: begin
                    if (flushM)
                        cancel <= 1'b1;
                    if (data_addr_ok)
                        state <= DATA;
                end
                DATA: begin
                    if (flushM)
                        cancel <= 1'b1;
                    if (data_data_ok) begin
                        cancel <= 1'b0;
                        if (stallM && !discard) begin
                            state     <= DONE;
                            held_data <= load_ext;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                DONE: begin
                    if (!stallM || flushM) begin
                        state     <= IDLE;
                        held_data <= 32'h0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit: a delay-programmable slave, a retirement
// monitor popping a scoreboard queue, and a reference model of the load/store rules.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        memenM = 1'b0;
    logic        memwriteM = 1'b0;
    logic [2:0]  lsopM = 3'b000;
    logic [31:0] addrM = 32'h0;
    logic [31:0] writedataM = 32'h0;
    logic        stallM = 1'b0;
    logic        flushM = 1'b0;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok = 1'b0;
    logic        data_data_ok = 1'b0;
    logic [31:0] data_rdata = 32'h0;
    logic        stall_reqM;
    logic        adelM;
    logic        adesM;
    logic [31:0] badvaddrM;
    logic [31:0] readdataM;

    mem_access_unit dut (
        .clk(clk), .rst(rst), .memenM(memenM), .memwriteM(memwriteM), .lsopM(lsopM),
        .addrM(addrM), .writedataM(writedataM), .stallM(stallM), .flushM(flushM),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata), .stall_reqM(stall_reqM), .adelM(adelM), .adesM(adesM),
        .badvaddrM(badvaddrM), .readdataM(readdataM)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // {adel, ades, badvaddr, readdata} expected at retirement
    logic [65:0] exp_q[$];
    // {wr, size, addr, wdata} expected on the request bus
    logic [66:0] req_q[$];

    int          sl_a_dly = 0;
    int          sl_d_dly = 0;
    logic [31:0] sl_rdata = 32'h0;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int op_bytes(input logic [2:0] op);
        case (op)
            3'd0, 3'd1, 3'd5: return 1;
            3'd2, 3'd3, 3'd6: return 2;
            default:          return 4;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] addr,
                                               input logic [31:0] rd);
        logic [31:0] b;
        logic [31:0] h;
        b = (rd >> (8 * (addr % 4))) & 32'hFF;
        h = (rd >> (16 * ((addr % 4) / 2))) & 32'hFFFF;
        case (op)
            3'd0:    return (b >= 32'h80) ? b + 32'hFFFF_FF00 : b;
            3'd1:    return b;
            3'd2:    return (h >= 32'h8000) ? h + 32'hFFFF_0000 : h;
            3'd3:    return h;
            3'd4:    return rd;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] model_wdata(input int nbytes, input logic [31:0] wd);
        if (nbytes == 1) return (wd & 32'hFF) * 32'h0101_0101;
        if (nbytes == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    // Retirement monitor: M advances when it is not held by anyone.
    logic [65:0] mon_e;
    always @(negedge clk) begin
        if (rst && memenM && !stall_reqM && !stallM) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL retire_unexpected: got retirement at addr %0h, expected none", addrM);
            end else begin
                mon_e = exp_q.pop_front();
                chk("retire_adel", 80'(adelM), 80'(mon_e[65]));
                chk("retire_ades", 80'(adesM), 80'(mon_e[64]));
                chk("retire_badvaddr", 80'(badvaddrM), 80'(mon_e[63:32]));
                chk("retire_readdata", 80'(readdataM), 80'(mon_e[31:0]));
            end
        end
    end

    // Slave: addr_ok after sl_a_dly cycles of request, data_ok sl_d_dly cycles into DATA.
    int          sl_phase = 0;
    int          sl_cnt = 0;
    logic [66:0] sl_cap;
    logic [66:0] sl_exp;
    initial begin
        forever begin
            @(posedge clk);
            #2;
            data_addr_ok = 1'b0;
            data_data_ok = 1'b0;
            data_rdata   = $urandom;
            if (!rst) begin
                sl_phase = 0;
            end else begin
                case (sl_phase)
                    0: if (data_req) begin
                        sl_cap = {data_wr, data_size, data_addr, data_wdata};
                        if (req_q.size() == 0) begin
                            n_tests++;
                            n_fail++;
                            $display("FAIL unexpected_req: got request addr %0h, expected none", data_addr);
                        end else begin
                            sl_exp = req_q.pop_front();
                            chk("req_fields", 80'(sl_cap), 80'(sl_exp));
                        end
                        if (sl_a_dly == 0) begin
                            data_addr_ok = 1'b1;
                            sl_cnt   = sl_d_dly;
                            sl_phase = 2;
                        end else begin
                            sl_cnt   = sl_a_dly;
                            sl_phase = 1;
                        end
                    end
                    1: begin
                        chk("req_held", 80'({data_req, data_wr, data_size, data_addr, data_wdata}),
                            80'({1'b1, sl_cap}));
                        sl_cnt--;
                        if (sl_cnt == 0) begin
                            data_addr_ok = 1'b1;
                            sl_cnt   = sl_d_dly;
                            sl_phase = 2;
                        end
                    end
                    default: begin
                        chk("no_req_in_data", 80'(data_req), 80'(0));
                        if (sl_cnt == 0) begin
                            data_data_ok = 1'b1;
                            data_rdata   = sl_rdata;
                            sl_phase     = 0;
                        end else begin
                            sl_cnt--;
                        end
                    end
                endcase
            end
        end
    end

    task automatic run_op(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rd, input int a_dly, input int d_dly,
                          input int hold, input bit flush);
        bit          wr;
        int          nbytes;
        bit          mis;
        logic [31:0] exp_rd;
        int          exp_stalls;
        int          stalls;
        int          k;
        int          rem;
        bit          done_seen;
        bit          retired;
        wr     = (op >= 3'd5);
        nbytes = op_bytes(op);
        mis    = (addr % nbytes) != 0;
        exp_rd = (mis || wr || flush) ? 32'h0 : model_load(op, addr, rd);
        exp_stalls = mis ? 0 : a_dly + 1 + d_dly;
        exp_q.push_back({mis && !wr, mis && wr, addr, exp_rd});
        if (!mis)
            req_q.push_back({wr, 2'((nbytes == 1) ? 0 : (nbytes == 2) ? 1 : 2), addr,
                             model_wdata(nbytes, wd)});
        sl_a_dly = a_dly;
        sl_d_dly = d_dly;
        sl_rdata = rd;
        @(posedge clk);
        #1;
        memenM = 1'b1; memwriteM = wr; lsopM = op; addrM = addr; writedataM = wd;
        stallM = (hold > 0); flushM = 1'b0;
        stalls = 0; k = 0; rem = hold; done_seen = 0; retired = 0;
        while (!retired && k < 100) begin
            @(negedge clk);
            if (stall_reqM) stalls++;
            if (done_seen && stallM) chk("done_hold", 80'(readdataM), 80'(exp_rd));
            if (data_data_ok) done_seen = 1;
            if (!stall_reqM && !stallM) begin
                retired = 1;
            end else begin
                @(posedge clk);
                #1;
                k++;
                flushM = flush && (k == 1);
                if (done_seen) begin
                    if (rem > 0) rem--;
                    else stallM = 1'b0;
                end
            end
        end
        if (!retired) begin
            n_tests++;
            n_fail++;
            $display("FAIL retire_timeout: got no retirement in 100 cycles, expected one (addr %0h)", addr);
        end
        chk("stall_cycles", 80'(stalls), 80'(exp_stalls));
        @(posedge clk);
        #1;
        memenM = 1'b0; stallM = 1'b0; flushM = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_req"}, 80'(data_req), 80'(0));
        chk({tag, "_wr"}, 80'(data_wr), 80'(0));
        chk({tag, "_size"}, 80'(data_size), 80'(0));
        chk({tag, "_stall"}, 80'(stall_reqM), 80'(0));
        chk({tag, "_adel"}, 80'(adelM), 80'(0));
        chk({tag, "_ades"}, 80'(adesM), 80'(0));
        chk({tag, "_rdata"}, 80'(readdataM), 80'(0));
    endtask

    task automatic reset_mid_data();
        req_q.push_back({1'b0, 2'd2, 32'h0000_3000, 32'h0});
        sl_a_dly = 0;
        sl_d_dly = 6;
        sl_rdata = 32'h5555_AAAA;
        @(posedge clk);
        #1;
        memenM = 1'b1; memwriteM = 1'b0; lsopM = 3'd4; addrM = 32'h0000_3000;
        writedataM = 32'h0; stallM = 1'b0; flushM = 1'b0;
        @(negedge clk);
        chk("rstdata_issue_stall", 80'(stall_reqM), 80'(1));
        @(posedge clk);
        #1;
        chk("rstdata_wait_stall", 80'(stall_reqM), 80'(1));
        rst = 1'b0;
        #1;
        chk("rstdata_req", 80'(data_req), 80'(0));
        chk("rstdata_stall", 80'(stall_reqM), 80'(0));
        chk("rstdata_rdata", 80'(readdataM), 80'(0));
        memenM = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test by 200000, expected earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  op;
        logic [31:0] addr;
        int          a_dly;
        int          d_dly;
        int          hold;
        bit          flush;
        int          nb;

        memwriteM = 1'b1; lsopM = 3'd7; addrM = 32'h0000_2001; writedataM = 32'hCAFE_F00D;
        repeat (3) @(posedge clk);
        #1;
        check_quiet("in_reset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_quiet("after_reset");
        chk("idle_addr", 80'(data_addr), 80'(32'h0000_2001));
        chk("idle_badv", 80'(badvaddrM), 80'(32'h0000_2001));
        chk("idle_wdata", 80'(data_wdata), 80'(32'hCAFE_F00D));

        run_op(3'd4, 32'h0000_1004, 32'h0,         32'hDEAD_BEEF, 0, 0, 0, 0);
        run_op(3'd0, 32'h0000_1003, 32'h0,         32'h80FF_0011, 0, 0, 0, 0);
        run_op(3'd1, 32'h0000_1003, 32'h0,         32'h80FF_0011, 0, 0, 0, 0);
        run_op(3'd3, 32'h0000_1002, 32'h0,         32'h80FF_0011, 0, 0, 0, 0);
        run_op(3'd2, 32'h0000_1002, 32'h0,         32'h80FF_0011, 1, 2, 0, 0);
        run_op(3'd6, 32'h0000_2001, 32'h1234_5678, 32'h0,         0, 0, 0, 0);
        run_op(3'd4, 32'h0000_2002, 32'h0,         32'h0,         0, 0, 0, 0);
        run_op(3'd5, 32'h0000_2000, 32'h1234_56AB, 32'h0,         3, 0, 0, 0);
        run_op(3'd4, 32'h0000_2004, 32'h0,         32'h0000_0042, 0, 0, 2, 0);
        run_op(3'd4, 32'h0000_2008, 32'h0,         32'h7777_7777, 2, 1, 0, 1);
        reset_mid_data();
        run_op(3'd7, 32'h0000_200C, 32'h0BAD_F00D, 32'h0,         0, 0, 0, 0);

        for (int i = 0; i < 80; i++) begin
            op    = 3'($urandom_range(0, 7));
            addr  = {$urandom_range(0, 32'hFFFF), 16'h0} | 32'($urandom_range(0, 15));
            nb    = op_bytes(op);
            a_dly = $urandom_range(0, 3);
            d_dly = $urandom_range(0, 3);
            hold  = 0;
            flush = 0;
            if ((addr % nb) == 0) begin
                if ($urandom_range(0, 3) == 0)
                    hold = $urandom_range(1, 3);
                else if (a_dly > 0 && $urandom_range(0, 5) == 0)
                    flush = 1;
            end
            run_op(op, addr, $urandom, $urandom, a_dly, d_dly, hold, flush);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (3) @(posedge clk);
        chk("exp_q_drained", 80'(exp_q.size()), 80'(0));
        chk("req_q_drained", 80'(req_q.size()), 80'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
